pu_accum: RTL and testbench
===========================

Name: pu_accum

Overview:
- Accumulator processing unit on the shared data/attr bus, directly downstream of the multiplier PU.
- Consumes products (and any other bus values) and forms signed running sums/differences.
- Propagates and generates the INVALID attribute bit.
- Two-stage registered pipeline; result readable over the bus under signal_oe.

Parameters:
- DATA_WIDTH, 32, bus data width; two's-complement signed operands.
- ATTR_WIDTH, 4, attribute field width; attr ports are ATTR_WIDTH+1 bits wide.
- INVALID, 0, index of the invalid flag within attr.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- signal_wr  input  1  operand write strobe, one operand per cycle.
- signal_init  input  1  qualified by signal_wr; 1 = load operand as a new sum, 0 = accumulate.
- signal_neg  input  1  qualified by signal_wr; 1 = use the negated operand.
- data_in  input  DATA_WIDTH  operand.
- attr_in  input  ATTR_WIDTH+1  operand attributes; only bit INVALID is used.
- signal_oe  input  1  result output enable.
- data_out  output  DATA_WIDTH  accumulator value when signal_oe=1, else 0.
- attr_out  output  ATTR_WIDTH+1  bit INVALID = sticky invalid when signal_oe=1; all other bits 0; all 0 when signal_oe=0.

Behaviour:
- Reset (async, any time, including mid-accumulation):
  - acc, inv, and all stage-1 registers cleared to 0.
  - data_out and attr_out are 0 during and after reset.
  - In-flight operands are discarded.
- Stage 1 (cycle N, signal_wr=1):
  - Register data_in, attr_in[INVALID], signal_init and signal_neg into op_q, opinv_q, init_q, neg_q.
  - Set wr_q=1; wr_q=0 when signal_wr=0.
  - signal_init and signal_neg are ignored when signal_wr=0.
- Negation, in stage 1 or stage 2:
  - neg_q=1 yields operand = -op_q, computed in DATA_WIDTH bits.
  - Negating the most negative value (100..0) raises an operand overflow.
- Stage 2 (cycle N+1, wr_q=1):
  - init_q=1: acc <= operand; inv <= opinv_q | operand overflow.
  - init_q=0: acc <= acc + operand, wrapping at DATA_WIDTH bits; inv <= inv | opinv_q | operand overflow | add overflow.
  - Add overflow: both addends have the same sign bit and the sum's sign bit differs.
- Latency: an operand written at edge N is visible on data_out from edge N+2 onward.
- Back-to-back writes every cycle are supported; each cycle's operand is accumulated in order with no bubble.
- signal_oe is purely combinational gating of the acc/inv registers. Reading does not clear or alter state.
- Simultaneous signal_wr and signal_oe: output shows acc before that write's effect.
- Invalid flag:
  - Sticky across accumulation.
  - Cleared only by an init load whose operand is valid and does not overflow, or by rst.
- Without writes, acc and inv hold indefinitely.

Optional Feature:
- Macro: PU_ACCUM_SATURATE_EN.
- Defined: on any add or negation overflow, acc saturates instead of wrapping.
  - Positive overflow -> 011..1.
  - Negative overflow -> 100..0.
  - Negating 100..0 -> 011..1.
  - inv is still set exactly as in the non-saturating case.
- Undefined: pure wrap-around arithmetic as described in Behaviour; no saturation logic is synthesized.

Test Plan:
- Reset then signal_oe=1 -> data_out=0, attr_out=0. Assert rst mid-sequence after writing 5 -> next read is 0/0 immediately, including before the next clk edge.
- Write 7 (init=1) at edge 0, 5 at edge 1, 3 with neg=1 at edge 2, all back-to-back -> data_out=7 at edge 2, 12 at edge 3, 9 from edge 4; attr_out=0 throughout.
- Write 0x7FFFFFF0 (init=1), then 0x20 -> without the macro, data_out=0x80000010 and attr_out[INVALID]=1; with PU_ACCUM_SATURATE_EN, data_out=0x7FFFFFFF and attr_out[INVALID]=1.
- Write 4 with attr_in[INVALID]=1 (init=1), then 6 valid -> data_out=10 with invalid=1. Then write 2 (init=1) valid -> data_out=2, invalid=0.
- Write 0x80000000 with init=1, neg=1 -> invalid=1; data_out=0x80000000 without the macro, 0x7FFFFFFF with it.
- signal_oe=0 while acc=12 -> data_out=0, attr_out=0. Write 1 with signal_oe=1 in the same cycle -> that cycle reads 12, and 13 from two edges later.

Source files
------------

// File: rtl/pu_accum.sv
// Accumulator PU: two-stage pipeline forming signed running sums with sticky INVALID.
// Optional macro PU_ACCUM_SATURATE_EN makes negation/add overflow saturate instead of wrap.
module pu_accum #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ATTR_WIDTH = 4,
    parameter int unsigned INVALID    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signal_wr,
    input  logic                  signal_init,
    input  logic                  signal_neg,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ATTR_WIDTH:0]   attr_in,
    input  logic                  signal_oe,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [ATTR_WIDTH:0]   attr_out
);

    localparam logic [DATA_WIDTH-1:0] MIN_VAL = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] MAX_VAL = {1'b0, {(DATA_WIDTH-1){1'b1}}};

    logic [DATA_WIDTH-1:0] op_q;
    logic                  opinv_q;
    logic                  init_q;
    logic                  neg_q;
    logic                  wr_q;

    logic [DATA_WIDTH-1:0] acc;
    logic                  inv;

    logic [DATA_WIDTH-1:0] operand_raw;
    logic [DATA_WIDTH-1:0] operand;
    logic                  neg_ovf;
    logic [DATA_WIDTH-1:0] sum_raw;
    logic [DATA_WIDTH-1:0] sum_res;
    logic                  add_ovf;
    logic                  attr_unused;

    // Only the INVALID bit of attr_in carries meaning.
    assign attr_unused = ^attr_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= '0;
            opinv_q <= 1'b0;
            init_q  <= 1'b0;
            neg_q   <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            wr_q <= signal_wr;
            if (signal_wr) begin
                op_q    <= data_in;
                opinv_q <= attr_in[INVALID];
                init_q  <= signal_init;
                neg_q   <= signal_neg;
            end
        end
    end

    assign operand_raw = neg_q ? (~op_q + 1'b1) : op_q;
    assign neg_ovf     = neg_q && (op_q == MIN_VAL);

    assign sum_raw = acc + operand;
    assign add_ovf = (acc[DATA_WIDTH-1] == operand[DATA_WIDTH-1]) &&
                     (sum_raw[DATA_WIDTH-1] != acc[DATA_WIDTH-1]);

`ifdef PU_ACCUM_SATURATE_EN
    // The saturated operand feeds the adder, so -MIN contributes +MAX.
    assign operand = neg_ovf ? MAX_VAL : operand_raw;
    assign sum_res = add_ovf ? (acc[DATA_WIDTH-1] ? MIN_VAL : MAX_VAL) : sum_raw;
`else
    assign operand = operand_raw;
    assign sum_res = sum_raw;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            inv <= 1'b0;
        end else if (wr_q) begin
            if (init_q) begin
                acc <= operand;
                inv <= opinv_q | neg_ovf;
            end else begin
                acc <= sum_res;
                inv <= inv | opinv_q | neg_ovf | add_ovf;
            end
        end
    end

    always_comb begin
        data_out          = signal_oe ? acc : '0;
        attr_out          = '0;
        attr_out[INVALID] = signal_oe & inv;
    end

endmodule

// File: tb/tb_pu_accum.sv
// Directed self-checking bench for pu_accum; expectations follow PU_ACCUM_SATURATE_EN when defined.
module tb_pu_accum;

    logic        clk;
    logic        rst;
    logic        signal_wr;
    logic        signal_init;
    logic        signal_neg;
    logic [31:0] data_in;
    logic [4:0]  attr_in;
    logic        signal_oe;
    logic [31:0] data_out;
    logic [4:0]  attr_out;

    int unsigned errors = 0;
    int unsigned checks = 0;

    pu_accum #(
        .DATA_WIDTH(32),
        .ATTR_WIDTH(4),
        .INVALID(0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .signal_wr(signal_wr),
        .signal_init(signal_init),
        .signal_neg(signal_neg),
        .data_in(data_in),
        .attr_in(attr_in),
        .signal_oe(signal_oe),
        .data_out(data_out),
        .attr_out(attr_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_wr(input logic [31:0] d, input logic init, input logic neg,
                         input logic [4:0] attr);
        signal_wr   = 1'b1;
        data_in     = d;
        signal_init = init;
        signal_neg  = neg;
        attr_in     = attr;
        tick();
    endtask

    task automatic idle();
        signal_wr   = 1'b0;
        signal_init = 1'b1;
        signal_neg  = 1'b1;
        data_in     = 32'hDEAD_BEEF;
        attr_in     = 5'b11111;
        tick();
    endtask

    initial begin
        rst         = 1'b1;
        signal_wr   = 1'b0;
        signal_init = 1'b0;
        signal_neg  = 1'b0;
        data_in     = '0;
        attr_in     = '0;
        signal_oe   = 1'b1;
        tick();
        check("rst_data", data_out, 32'd0);
        check("rst_attr", {27'd0, attr_out}, 32'd0);
        rst = 1'b0;
        tick();
        check("post_rst_data", data_out, 32'd0);
        check("post_rst_attr", {27'd0, attr_out}, 32'd0);

        // back-to-back 7, +5, -3
        do_wr(32'd7, 1'b1, 1'b0, 5'b00000);
        check("lat_not_yet", data_out, 32'd0);
        do_wr(32'd5, 1'b0, 1'b0, 5'b00000);
        check("b2b_7", data_out, 32'd7);
        do_wr(32'd3, 1'b0, 1'b1, 5'b11110);
        check("b2b_12", data_out, 32'd12);
        idle();
        check("b2b_9", data_out, 32'd9);
        check("b2b_attr", {27'd0, attr_out}, 32'd0);
        idle();
        idle();
        check("hold_9", data_out, 32'd9);

        // output gating and read during write
        do_wr(32'd12, 1'b1, 1'b0, 5'b00000);
        idle();
        signal_oe = 1'b0;
        #1;
        check("oe0_data", data_out, 32'd0);
        check("oe0_attr", {27'd0, attr_out}, 32'd0);
        signal_oe   = 1'b1;
        signal_wr   = 1'b1;
        data_in     = 32'd1;
        signal_init = 1'b0;
        signal_neg  = 1'b0;
        attr_in     = 5'b00000;
        #1;
        check("rdwr_same", data_out, 32'd12);
        tick();
        check("rdwr_edge1", data_out, 32'd12);
        idle();
        check("rdwr_13", data_out, 32'd13);

        // positive add overflow
        do_wr(32'h7FFF_FFF0, 1'b1, 1'b0, 5'b00000);
        do_wr(32'h0000_0020, 1'b0, 1'b0, 5'b00000);
        check("povf_pre", data_out, 32'h7FFF_FFF0);
        idle();
`ifdef PU_ACCUM_SATURATE_EN
        check("povf_data", data_out, 32'h7FFF_FFFF);
`else
        check("povf_data", data_out, 32'h8000_0010);
`endif
        check("povf_attr", {27'd0, attr_out}, 32'd1);

        // negative add overflow via negated operand
        do_wr(32'h8000_0010, 1'b1, 1'b0, 5'b00000);
        do_wr(32'h0000_0020, 1'b0, 1'b1, 5'b00000);
        idle();
`ifdef PU_ACCUM_SATURATE_EN
        check("novf_data", data_out, 32'h8000_0000);
`else
        check("novf_data", data_out, 32'h7FFF_FFF0);
`endif
        check("novf_attr", {27'd0, attr_out}, 32'd1);

        // invalid propagation, stickiness, clearing by valid init
        do_wr(32'd4, 1'b1, 1'b0, 5'b00001);
        do_wr(32'd6, 1'b0, 1'b0, 5'b00000);
        idle();
        check("inv_sum", data_out, 32'd10);
        check("inv_sticky", {27'd0, attr_out}, 32'd1);
        do_wr(32'd2, 1'b1, 1'b0, 5'b00000);
        idle();
        check("inv_clr_data", data_out, 32'd2);
        check("inv_clr_attr", {27'd0, attr_out}, 32'd0);

        // negating the most negative value
        do_wr(32'h8000_0000, 1'b1, 1'b1, 5'b00000);
        idle();
`ifdef PU_ACCUM_SATURATE_EN
        check("negmin_data", data_out, 32'h7FFF_FFFF);
`else
        check("negmin_data", data_out, 32'h8000_0000);
`endif
        check("negmin_attr", {27'd0, attr_out}, 32'd1);

        // async reset mid-accumulation, with an operand in flight
        do_wr(32'd5, 1'b1, 1'b0, 5'b00000);
        idle();
        check("pre_rst_5", data_out, 32'd5);
        do_wr(32'd9, 1'b0, 1'b0, 5'b00001);
        signal_wr = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_data", data_out, 32'd0);
        check("async_rst_attr", {27'd0, attr_out}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        tick();
        check("flight_drop_data", data_out, 32'd0);
        check("flight_drop_attr", {27'd0, attr_out}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
